sp_usb_fifo_dev: RTL and testbench
==================================

SP_USB_FIFO_DEV -- requirements
Module: sp_usb_fifo_dev

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning entries per direction FIFO (power of two, >=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port usb_data  inout  8  shared bus to FPGA-side FIFO master.
REQ-006 SHALL have port rxf_n  output  1  low = device holds byte for master to read.
REQ-007 SHALL have port txe_n  output  1  low = device can accept byte from master.
REQ-008 SHALL have port rd_n  input  1  master read strobe, active-low, one byte per sampled-low cycle.
REQ-009 SHALL have port wr_n  input  1  master write strobe, active-low, one byte per sampled-low cycle.
REQ-010 SHALL have ports host_din  input  8, host_write  input  1, host_full  output  1: host push into RX FIFO (toward master).
REQ-011 SHALL have ports host_dout  output  8, host_read  input  1, host_avail  output  1: host pop from TX FIFO (from master).
REQ-012 SHALL have port err  output  2  sticky errors: bit0 read-while-empty, bit1 write-while-full.

Function
REQ-013 SHALL push host_din into RX FIFO on posedge when host_write=1 and host_full=0; host_write while full SHALL be ignored.
REQ-014 SHALL drive rxf_n as a register equal to RX-empty of the post-edge count (updated same edge as push/pop).
REQ-015 SHALL drive usb_data with RX FIFO head whenever rxf_n=0 and wr_n=1, else high-Z.
REQ-016 SHALL pop RX FIFO on posedge when rd_n=0, wr_n=1, rxf_n=0; byte consumed is the one on usb_data that cycle.
REQ-017 SHALL drive txe_n as a register equal to TX-full of the post-edge count.
REQ-018 SHALL push usb_data into TX FIFO on posedge when wr_n=0 and txe_n=0.
REQ-019 SHALL assert host_avail = TX not empty; host_dout = TX head (combinational from storage); pop on host_read=1 with host_avail=1; host_read while empty ignored.
REQ-020 SHALL keep count unchanged on simultaneous push and pop of the same FIFO, including when full (pop frees, push fills) and SHALL not lose data.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count width ADDR_WIDTH+1; full = count==DEPTH.
REQ-022 SHALL, when rd_n=0 and rxf_n=1, perform no pop and set err[0].
REQ-023 SHALL, when wr_n=0 and txe_n=1, drop the byte and set err[1].
REQ-024 SHALL, when rd_n=0 and wr_n=0 in the same cycle, service the write only, perform no pop, set err[0].
REQ-025 SHALL have per-direction latency: host push to rxf_n low 1 cycle; master write to host_avail high 1 cycle.

Reset
REQ-026 SHALL on rst_n=0, asynchronously: rxf_n=1, txe_n=0, host_full=0, host_avail=0, err=0, pointers and counts=0, usb_data high-Z.
REQ-027 SHALL discard all FIFO contents on reset asserted mid-transfer; first post-reset edge behaves as from empty.
REQ-028 SHALL leave storage arrays unreset (contents unobservable while empty).

Structure
REQ-029 SHALL place bus width (8), error bit indices and default DEPTH in shared package sp_usb_pkg.
REQ-030 SHALL instantiate one sub-module sp_fifo_sync (parameters DEPTH, ADDR_WIDTH, WIDTH=8) twice, RX and TX; it exports count, full, empty, head.
REQ-031 SHALL keep the tri-state driver, error logic and registered flags in sp_usb_fifo_dev top.

Verification
REQ-032 SHALL cover: host writes 0x11,0x22,0x33; master rd_n low 3 cycles -> usb_data shows 0x11,0x22,0x33 in order, rxf_n high the edge after third pop.
REQ-033 SHALL cover: master writes 16 bytes 0x00..0x0F with host_read=0 -> txe_n high after 16th edge; 17th write 0xFF dropped, err=2'b10; host then reads 0x00..0x0F.
REQ-034 SHALL cover: TX full, wr_n=0 and host_read=1 same edge -> count stays 16, txe_n stays 1 only if count==16, no data lost.
REQ-035 SHALL cover: rd_n=0 with RX empty -> no pop, err[0]=1, usb_data high-Z.
REQ-036 SHALL cover: rd_n=0 and wr_n=0 with RX holding 0x5A -> write stored, 0x5A remains, err[0]=1.
REQ-037 SHALL cover: rst_n pulsed low mid-burst with 5 bytes queued -> outputs immediately at reset values, subsequent reads see empty.

Source files
------------

// File: rtl/sp_usb_pkg.sv
// rtl/sp_usb_pkg.sv - shared constants for the USB FIFO device
// Bus width, default FIFO depth and sticky error bit positions.
package sp_usb_pkg;

  localparam int BUS_WIDTH     = 8;
  localparam int DEFAULT_DEPTH = 16;

  localparam int ERR_WIDTH    = 2;
  localparam int ERR_RD_EMPTY = 0;
  localparam int ERR_WR_FULL  = 1;

  typedef logic [BUS_WIDTH-1:0] usb_byte_t;

endpackage

// File: rtl/sp_fifo_sync.sv
// rtl/sp_fifo_sync.sv - single-clock circular FIFO with count/full/empty/head
// Storage is unreset; pointers and count clear asynchronously.
module sp_fifo_sync #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [WIDTH-1:0]      head
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sp_usb_fifo_dev.sv
// rtl/sp_usb_fifo_dev.sv - FIFO-style USB device bridging a bus master and a host
// RX carries host bytes to the master, TX carries master bytes to the host.
module sp_usb_fifo_dev
  import sp_usb_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire  [BUS_WIDTH-1:0] usb_data,
  output logic                 rxf_n,
  output logic                 txe_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic [BUS_WIDTH-1:0] host_din,
  input  logic                 host_write,
  output logic                 host_full,
  output logic [BUS_WIDTH-1:0] host_dout,
  input  logic                 host_read,
  output logic                 host_avail,
  output logic [ERR_WIDTH-1:0] err
);

  localparam logic [ADDR_WIDTH:0] ONE_COUNT    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] ALMOST_COUNT = (ADDR_WIDTH+1)'(DEPTH - 1);

  logic [ADDR_WIDTH:0]  rx_count;
  logic                 rx_full;
  logic                 rx_empty;
  usb_byte_t            rx_head;
  logic                 rx_push;
  logic                 rx_pop;

  logic [ADDR_WIDTH:0]  tx_count;
  logic                 tx_full;
  logic                 tx_empty;
  usb_byte_t            tx_head;
  logic                 tx_push;
  logic                 tx_pop;

  logic                 rxf_n_next;
  logic                 txe_n_next;
  logic                 err_rd;
  logic                 err_wr;

  // Master writes take priority: a read strobe during a write never pops.
  assign rx_push = host_write && !rx_full;
  assign rx_pop  = !rd_n && wr_n && !rxf_n;
  assign tx_pop  = host_read && !tx_empty;
  assign tx_push = !wr_n && (!txe_n || tx_pop);

  assign err_rd = !rd_n && (rxf_n || !wr_n);
  assign err_wr = !wr_n && !tx_push;

  assign host_full  = rx_full;
  assign host_avail = !tx_empty;
  assign host_dout  = tx_head;

  assign usb_data = (!rxf_n && wr_n) ? rx_head : {BUS_WIDTH{1'bz}};

  // Flags track the count as it will be after this edge.
  always_comb begin
    rxf_n_next = 1'b1;
    txe_n_next = 1'b0;
    if (rx_empty) begin
      rxf_n_next = !rx_push;
    end else begin
      rxf_n_next = (rx_count == ONE_COUNT) && rx_pop && !rx_push;
    end
    if (tx_full) begin
      txe_n_next = !(tx_pop && !tx_push);
    end else begin
      txe_n_next = (tx_count == ALMOST_COUNT) && tx_push && !tx_pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxf_n <= 1'b1;
      txe_n <= 1'b0;
      err   <= '0;
    end else begin
      rxf_n <= rxf_n_next;
      txe_n <= txe_n_next;
      if (err_rd) begin
        err[ERR_RD_EMPTY] <= 1'b1;
      end
      if (err_wr) begin
        err[ERR_WR_FULL] <= 1'b1;
      end
    end
  end

  sp_fifo_sync #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (BUS_WIDTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (host_din),
    .pop       (rx_pop),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  sp_fifo_sync #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (BUS_WIDTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (usb_data),
    .pop       (tx_pop),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_head)
  );

endmodule

// File: tb/tb_sp_usb_fifo_dev.sv
// tb/tb_sp_usb_fifo_dev.sv - self-checking bench for sp_usb_fifo_dev
// Queue model checked every negedge plus directed literal expectations.
module tb_sp_usb_fifo_dev;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       host_write = 1'b0;
  logic       host_read = 1'b0;
  logic [7:0] host_din = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic       m_oe = 1'b0;

  wire  [7:0] usb_data;
  logic       rxf_n;
  logic       txe_n;
  logic       host_full;
  logic [7:0] host_dout;
  logic       host_avail;
  logic [1:0] err;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [1:0] m_err = 2'b00;
  bit         m_rx_pop, m_rx_push, m_tx_pop, m_tx_push;

  always #5 clk = ~clk;

  assign usb_data = m_oe ? m_data : 8'bzzzzzzzz;
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (usb_data[g]);
  end

  sp_usb_fifo_dev #(.DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .usb_data   (usb_data),
    .rxf_n      (rxf_n),
    .txe_n      (txe_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .host_din   (host_din),
    .host_write (host_write),
    .host_full  (host_full),
    .host_dout  (host_dout),
    .host_read  (host_read),
    .host_avail (host_avail),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queues and the rules of who may push/pop each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q.delete();
      tx_q.delete();
      m_err = 2'b00;
    end else begin
      m_rx_pop  = !rd_n && wr_n && (rx_q.size() != 0);
      m_rx_push = host_write && (rx_q.size() < DEPTH);
      m_tx_pop  = host_read && (tx_q.size() != 0);
      m_tx_push = !wr_n && ((tx_q.size() < DEPTH) || m_tx_pop);
      if (!rd_n && ((rx_q.size() == 0) || !wr_n)) m_err[0] = 1'b1;
      if (!wr_n && !m_tx_push) m_err[1] = 1'b1;
      if (m_rx_pop) void'(rx_q.pop_front());
      if (m_rx_push) rx_q.push_back(host_din);
      if (m_tx_pop) void'(tx_q.pop_front());
      if (m_tx_push) tx_q.push_back(m_data);
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_bus;
    chk("rxf_n", rxf_n, rx_q.size() == 0);
    chk("txe_n", txe_n, tx_q.size() == DEPTH);
    chk("host_full", host_full, rx_q.size() == DEPTH);
    chk("host_avail", host_avail, tx_q.size() != 0);
    chk("err", err, m_err);
    if (tx_q.size() != 0) chk("host_dout", host_dout, tx_q[0]);
    if (!wr_n) exp_bus = m_data;
    else if (rx_q.size() != 0) exp_bus = rx_q[0];
    else exp_bus = 8'hFF;
    chk("usb_data", usb_data, exp_bus);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rd_n = 1'b1; wr_n = 1'b1; m_oe = 1'b0;
    host_write = 1'b0; host_read = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_rxf_n", rxf_n, 1);
    chk("rst_txe_n", txe_n, 0);
    chk("rst_err", err, 2'b00);
    chk("rst_avail", host_avail, 0);
    chk("rst_full", host_full, 0);
    chk("rst_bus_z", usb_data, 8'hFF);
    rst_n = 1'b1;
    tick();

    // Host pushes three bytes, master reads them back in order.
    host_write = 1'b1; host_din = 8'h11;
    tick();
    chk("rx_latency", rxf_n, 0);
    host_din = 8'h22;
    tick();
    host_din = 8'h33;
    tick();
    host_write = 1'b0;
    rd_n = 1'b0;
    #1 chk("rd0", usb_data, 8'h11);
    tick();
    chk("rd1", usb_data, 8'h22);
    tick();
    chk("rd2", usb_data, 8'h33);
    tick();
    rd_n = 1'b1;
    chk("rx_empty_after3", rxf_n, 1);
    chk("rx_err_clean", err, 2'b00);

    // Master fills TX, 17th byte dropped, host drains.
    wr_n = 1'b0; m_oe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_data = 8'(i);
      tick();
      if (i == 0) chk("tx_latency", host_avail, 1);
      if (i == 14) chk("txe_n_at15", txe_n, 0);
    end
    chk("txe_n_at16", txe_n, 1);
    m_data = 8'hFF;
    tick();
    chk("tx_drop_err", err, 2'b10);
    wr_n = 1'b1; m_oe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("host_rd", host_dout, 32'(i));
      host_read = 1'b1;
      tick();
    end
    host_read = 1'b0;
    chk("tx_drained", host_avail, 0);

    // Full TX with simultaneous master write and host read keeps 16 entries.
    do_reset();
    wr_n = 1'b0; m_oe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_data = 8'h80 + 8'(i);
      tick();
    end
    m_data = 8'hA5; host_read = 1'b1;
    tick();
    wr_n = 1'b1; m_oe = 1'b0; host_read = 1'b0;
    chk("full_rw_txe", txe_n, 1);
    chk("full_rw_head", host_dout, 8'h81);
    chk("full_rw_noerr", err, 2'b00);
    host_read = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("full_rw_data", host_dout, 32'h80 + 32'(i));
      tick();
    end
    chk("full_rw_last", host_dout, 8'hA5);
    tick();
    host_read = 1'b0;
    chk("full_rw_empty", host_avail, 0);

    // Master read of empty RX.
    do_reset();
    rd_n = 1'b0;
    #1 chk("rd_empty_z", usb_data, 8'hFF);
    tick();
    rd_n = 1'b1;
    chk("rd_empty_err", err, 2'b01);
    chk("rd_empty_rxf", rxf_n, 1);

    // Simultaneous rd_n and wr_n with RX holding 0x5A.
    do_reset();
    host_write = 1'b1; host_din = 8'h5A;
    tick();
    host_write = 1'b0;
    rd_n = 1'b0; wr_n = 1'b0; m_oe = 1'b1; m_data = 8'hC3;
    tick();
    rd_n = 1'b1; wr_n = 1'b1; m_oe = 1'b0;
    chk("rdwr_err", err, 2'b01);
    chk("rdwr_rxf", rxf_n, 0);
    chk("rdwr_tx", host_dout, 8'hC3);
    #1 chk("rdwr_keep", usb_data, 8'h5A);

    // RX full boundary: 17th host byte ignored.
    do_reset();
    host_write = 1'b1;
    for (int i = 0; i < 17; i++) begin
      host_din = 8'h40 + 8'(i);
      tick();
    end
    host_write = 1'b0;
    chk("rx_full", host_full, 1);
    rd_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 chk("rx_full_data", usb_data, 32'h40 + 32'(i));
      tick();
    end
    rd_n = 1'b1;
    chk("rx_full_drained", rxf_n, 1);
    chk("rx_full_noerr", err, 2'b00);

    // Reset mid-burst with 5 bytes queued.
    do_reset();
    host_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_din = 8'h60 + 8'(i);
      tick();
    end
    host_write = 1'b0;
    rd_n = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rxf", rxf_n, 1);
    chk("mid_rst_txe", txe_n, 0);
    chk("mid_rst_bus", usb_data, 8'hFF);
    chk("mid_rst_avail", host_avail, 0);
    chk("mid_rst_err", err, 2'b00);
    rd_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rxf", rxf_n, 1);
    rd_n = 1'b0;
    #1 chk("post_rst_bus", usb_data, 8'hFF);
    tick();
    rd_n = 1'b1;
    chk("post_rst_err", err, 2'b01);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
